// File: rtl/difftest_snapshot_scheduler.sv
// difftest_snapshot_scheduler: periodic CSR snapshot requests, per-core buffering, round-robin serialisation to one sink
module difftest_snapshot_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_cfg_enable,
  input  logic [31:0]              io_cfg_interval,
  output logic [NUM_CORES-1:0]     io_snap_req,
  input  logic [NUM_CORES-1:0]     io_req_valid,
  output logic [NUM_CORES-1:0]     io_req_ready,
  input  logic [64*NUM_CORES-1:0]  io_req_minstret,
  input  logic [64*NUM_CORES-1:0]  io_req_mcycle,
  output logic                     io_out_enable,
  output logic [63:0]              io_out_minstret,
  output logic [63:0]              io_out_mcycle,
  output logic [7:0]               io_out_coreid,
  output logic                     io_busy,
  output logic                     io_round_done,
  output logic [15:0]              io_overrun_cnt,
  output logic [15:0]              io_timeout_cnt
);
  localparam int IW = $clog2(NUM_CORES);
  localparam logic [IW:0] NC = (IW+1)'(NUM_CORES);
  localparam logic [IW-1:0] LAST = IW'(NUM_CORES - 1);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_n;
  logic [31:0] cnt, tmo;
  logic [NUM_CORES-1:0] pending, slot_full, hs, gnt_mask;
  logic [63:0] slot_mi [NUM_CORES];
  logic [63:0] slot_mc [NUM_CORES];
  logic [IW-1:0] rr, gnt;
  logic [IW:0] sum;
  logic gnt_v, run, tick, tmo_hit, drained;
  assign run = io_cfg_enable && io_cfg_interval != 32'd0;
  assign tick = run && cnt == io_cfg_interval - 32'd1;
  assign io_req_ready = pending & ~slot_full;
  assign hs = io_req_valid & io_req_ready;
  assign io_busy = state == ACTIVE;
  assign tmo_hit = tmo == 32'(TIMEOUT - 1);
  assign drained = pending == '0 && slot_full == '0;
  assign gnt_mask = gnt_v ? NUM_CORES'(1) << gnt : '0;
  always_comb begin
    state_n = (state == IDLE && tick) ? ACTIVE : (state == ACTIVE && drained) ? IDLE : state;
    io_snap_req = {NUM_CORES{state == IDLE && tick}};
  end
  // scan downwards so the full slot closest to rr (smallest offset) wins
  always_comb begin
    gnt_v = 1'b0;
    gnt = '0;
    sum = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      sum = {1'b0, rr} + (IW+1)'(k);
      if (sum >= NC) sum = sum - NC;
      if (slot_full[sum[IW-1:0]]) begin
        gnt_v = 1'b1;
        gnt = sum[IW-1:0];
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (hs[i]) begin
        slot_mi[i] <= io_req_minstret[64*i +: 64];
        slot_mc[i] <= io_req_mcycle[64*i +: 64];
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
      tmo <= '0;
      pending <= '0;
      slot_full <= '0;
      rr <= '0;
      io_out_enable <= 1'b0;
      io_out_minstret <= '0;
      io_out_mcycle <= '0;
      io_out_coreid <= '0;
      io_round_done <= 1'b0;
      io_overrun_cnt <= '0;
      io_timeout_cnt <= '0;
    end else begin
      cnt <= (!run || cnt >= io_cfg_interval - 32'd1) ? '0 : cnt + 32'd1;
      slot_full <= (slot_full & ~gnt_mask) | hs;
      io_out_enable <= gnt_v;
      if (gnt_v) begin
        io_out_minstret <= slot_mi[gnt];
        io_out_mcycle <= slot_mc[gnt];
        io_out_coreid <= 8'(gnt);
        rr <= gnt == LAST ? '0 : gnt + IW'(1);
      end
      io_round_done <= state == ACTIVE && drained;
      if (state == IDLE) begin
        if (tick) begin
          pending <= '1;
          tmo <= '0;
        end
      end else begin
        tmo <= tmo + 32'd1;
        pending <= tmo_hit ? '0 : pending & ~hs;
        if (tmo_hit && io_timeout_cnt != 16'hFFFF) io_timeout_cnt <= io_timeout_cnt + 16'd1;
        if (tick && io_overrun_cnt != 16'hFFFF) io_overrun_cnt <= io_overrun_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_difftest_snapshot_scheduler.sv
// tb_difftest_snapshot_scheduler: vector table, directed corner sequences and randomized run against a reference model
module tb_difftest_snapshot_scheduler;
  localparam int N = 4;
  localparam int TO = 16;
  logic clock = 1'b0, reset = 1'b1, en = 1'b0;
  logic [31:0] iv = '0;
  logic [N-1:0] valid = '0;
  logic [64*N-1:0] mi = '0, mc = '0;
  logic [N-1:0] snap_req, req_ready;
  logic out_enable, busy, round_done;
  logic [63:0] out_minstret, out_mcycle;
  logic [7:0] out_coreid;
  logic [15:0] overrun_cnt, timeout_cnt;
  int tests = 0, errors = 0;

  difftest_snapshot_scheduler #(.NUM_CORES(N), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .io_cfg_enable(en), .io_cfg_interval(iv),
    .io_snap_req(snap_req), .io_req_valid(valid), .io_req_ready(req_ready),
    .io_req_minstret(mi), .io_req_mcycle(mc), .io_out_enable(out_enable),
    .io_out_minstret(out_minstret), .io_out_mcycle(out_mcycle), .io_out_coreid(out_coreid),
    .io_busy(busy), .io_round_done(round_done), .io_overrun_cnt(overrun_cnt),
    .io_timeout_cnt(timeout_cnt)
  );

  always #5 clock = ~clock;

  // reference model: one round at a time, slots as plain arrays
  longint m_cnt;
  bit m_act, m_oe, m_done;
  bit m_pend [N];
  bit m_full [N];
  longint unsigned m_smi [N], m_smc [N];
  longint unsigned m_omi, m_omc;
  int m_rr, m_tmo, m_ovr, m_tmoc, m_oid;

  logic [N-1:0] s_snap;
  logic s_oe, s_busy, s_done;
  logic [7:0] s_id;
  logic [63:0] s_mi;
  logic [15:0] s_ovr, s_tmoc;
  int ids [$];

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] snap;
    logic oe;
    logic [7:0] id;
    logic busy;
    logic done;
  } vec_t;
  vec_t tv [20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit tick_now();
    return en && iv != 0 && m_cnt == longint'(iv) - 1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r = '0;
    for (int i = 0; i < N; i++) r[i] = m_act && m_pend[i] && !m_full[i];
    return r;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_act = 0; m_oe = 0; m_done = 0; m_rr = 0; m_tmo = 0;
    m_ovr = 0; m_tmoc = 0; m_omi = 0; m_omc = 0; m_oid = 0;
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0;
      m_full[i] = 0;
    end
  endtask

  task automatic model_step();
    bit tk, was_act, drained;
    logic [N-1:0] rdy;
    int g;
    if (reset) begin
      model_reset();
      return;
    end
    tk = tick_now();
    rdy = exp_ready();
    was_act = m_act;
    drained = 1;
    for (int i = 0; i < N; i++) if (m_pend[i] || m_full[i]) drained = 0;
    g = -1;
    for (int k = 0; k < N; k++) if (g < 0 && m_full[(m_rr + k) % N]) g = (m_rr + k) % N;
    m_oe = g >= 0;
    if (g >= 0) begin
      m_omi = m_smi[g];
      m_omc = m_smc[g];
      m_oid = g;
      m_full[g] = 0;
      m_rr = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (valid[i] && rdy[i]) begin
        m_full[i] = 1;
        m_pend[i] = 0;
        m_smi[i] = mi[64*i +: 64];
        m_smc[i] = mc[64*i +: 64];
      end
    end
    if (was_act) begin
      if (tk && m_ovr < 65535) m_ovr++;
      if (m_tmo == TO - 1) begin
        for (int i = 0; i < N; i++) m_pend[i] = 0;
        if (m_tmoc < 65535) m_tmoc++;
      end
      m_tmo++;
    end
    m_done = was_act && drained;
    if (m_done) m_act = 0;
    else if (!was_act && tk) begin
      m_act = 1;
      m_tmo = 0;
      for (int i = 0; i < N; i++) m_pend[i] = 1;
    end
    if (!en || iv == 0 || tk || m_cnt >= longint'(iv)) m_cnt = 0;
    else m_cnt++;
  endtask

  task automatic check_all();
    chk("snap_req", snap_req, (!m_act && tick_now()) ? {N{1'b1}} : '0);
    chk("req_ready", req_ready, exp_ready());
    chk("out_enable", out_enable, m_oe);
    chk("out_minstret", out_minstret, m_omi);
    chk("out_mcycle", out_mcycle, m_omc);
    chk("out_coreid", out_coreid, 8'(m_oid));
    chk("busy", busy, m_act);
    chk("round_done", round_done, m_done);
    chk("overrun_cnt", overrun_cnt, 16'(m_ovr));
    chk("timeout_cnt", timeout_cnt, 16'(m_tmoc));
  endtask

  task automatic step();
    @(negedge clock);
    check_all();
    s_snap = snap_req; s_oe = out_enable; s_busy = busy; s_done = round_done;
    s_id = out_coreid; s_mi = out_minstret; s_ovr = overrun_cnt; s_tmoc = timeout_cnt;
    if (out_enable) ids.push_back(int'(out_coreid));
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_snap(input string name, input int max);
    bit ok = 0;
    for (int k = 0; k < max; k++) begin
      step();
      if (s_snap != '0) begin
        ok = 1;
        break;
      end
    end
    chk(name, ok, 1);
  endtask

  task automatic chk_ids(input string name, input int e0, input int e1, input int e2, input int e3, input int n);
    int e [4];
    e = '{e0, e1, e2, e3};
    chk({name, "_count"}, ids.size(), n);
    if (ids.size() == n) for (int i = 0; i < n; i++) chk($sformatf("%s_id%0d", name, i), ids[i], e[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int first, nsnap;
    bit seen;
    for (int c = 0; c < 20; c++) tv[c] = '{valid: '0, snap: '0, oe: 1'b0, id: 8'd0, busy: c >= 10 && c <= 17, done: 1'b0};
    tv[9].snap = '1;
    tv[19].snap = '1;
    tv[12].valid = '1;
    for (int c = 14; c <= 17; c++) begin
      tv[c].oe = 1'b1;
      tv[c].id = 8'(c - 14);
    end
    tv[18].done = 1'b1;
    for (int i = 0; i < N; i++) begin
      mi[64*i +: 64] = 64'(100 + i);
      mc[64*i +: 64] = 64'(1000 + i);
    end
    model_reset();
    repeat (3) step();
    chk("reset_oe", s_oe, 0);
    chk("reset_busy", s_busy, 0);
    chk("reset_mi", s_mi, 0);
    reset = 1'b0; en = 1'b1; iv = 32'd10;
    // interval 10, all cores answer 3 cycles after the request
    for (int c = 0; c < 20; c++) begin
      valid = tv[c].valid;
      step();
      chk($sformatf("tv%0d_snap", c), s_snap, tv[c].snap);
      chk($sformatf("tv%0d_oe", c), s_oe, tv[c].oe);
      chk($sformatf("tv%0d_busy", c), s_busy, tv[c].busy);
      chk($sformatf("tv%0d_done", c), s_done, tv[c].done);
      if (tv[c].oe) begin
        chk($sformatf("tv%0d_id", c), s_id, tv[c].id);
        chk($sformatf("tv%0d_mi", c), s_mi, 64'(100) + 64'(tv[c].id));
      end
    end
    // core 1 silent: round aborts, three records drain
    ids.delete();
    valid = 4'b1101; en = 1'b0;
    repeat (25) step();
    chk_ids("silent1", 0, 2, 3, 0, 3);
    chk("silent1_tmo", s_tmoc, 1);
    chk("silent1_busy", s_busy, 0);
    // only cores 0,1 answer: leaves rr at 2
    valid = 4'b0011; en = 1'b1; iv = 32'd30;
    wait_snap("snap_c", 40);
    en = 1'b0; ids.delete();
    repeat (25) step();
    chk_ids("rr01", 0, 1, 0, 0, 2);
    chk("rr01_tmo", s_tmoc, 2);
    // all cores valid in the same cycle: order 2,3,0,1 from t+2
    valid = '1; en = 1'b1;
    wait_snap("snap_d", 40);
    en = 1'b0; ids.delete(); first = -1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (s_oe && first < 0) first = k;
    end
    chk_ids("rr2", 2, 3, 0, 1, 4);
    chk("rr2_latency", first, 2);
    // interval 4, core 3 answers 9 cycles late: two lost ticks
    valid = 4'b0111; en = 1'b1; iv = 32'd4;
    wait_snap("snap_e", 10);
    ids.delete(); seen = 0;
    for (int k = 1; k <= 30; k++) begin
      valid = k == 9 ? 4'b1111 : 4'b0111;
      step();
      if (s_done) begin
        seen = 1;
        break;
      end
    end
    chk("ovr_done_seen", seen, 1);
    chk("ovr_cnt", s_ovr, 2);
    chk("ovr_count", ids.size(), 4);
    if (ids.size() > 0) chk("ovr_last_id", ids[$], 3);
    en = 1'b0;
    repeat (25) step();
    // reset while slots are still full discards them
    valid = '1; en = 1'b1; iv = 32'd30;
    wait_snap("snap_f", 40);
    en = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("rst_oe%0d", k), s_oe, 0);
      if (k == 0) begin
        chk("rst_busy", s_busy, 0);
        chk("rst_mi", s_mi, 0);
        chk("rst_id", s_id, 0);
        chk("rst_tmo", s_tmoc, 0);
        chk("rst_ovr", s_ovr, 0);
      end
    end
    // no ticks with interval 0 or enable low
    nsnap = 0; en = 1'b1; iv = 32'd0;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (s_snap != '0) nsnap++;
    end
    chk("iv0_snaps", nsnap, 0);
    nsnap = 0; en = 1'b0; iv = 32'd7;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (s_snap != '0) nsnap++;
    end
    chk("en0_snaps", nsnap, 0);
    // interval 1 ticks every cycle and piles up overruns
    en = 1'b1; iv = 32'd1; valid = '1;
    repeat (60) step();
    chk("iv1_ovr_nonzero", s_ovr != 0, 1);
    // randomized run against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 49) == 0) begin
        en = $urandom_range(0, 7) != 0;
        iv = 32'($urandom_range(0, 12));
      end
      reset = $urandom_range(0, 299) == 0;
      valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        mi[64*i +: 64] = {$urandom, $urandom};
        mc[64*i +: 64] = {$urandom, $urandom};
      end
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
